id_ex_stage: RTL and testbench
==============================

# id_ex_stage

- Decode/issue stage that sits directly upstream of the ALU.
- Each cycle it takes one fetched RV32I instruction, its PC and the register-file read data.
- It decodes the instruction into the ALU's 4-bit function code and selects and forwards the two operands.
- It registers everything into the ID/EX pipeline register that drives the ALU's `input_one`, `input_two` and `func` in the execute stage, honouring stall and flush from hazard control.

## Interface
Parameters:
- `XLEN`, 32: datapath width; only 32 is supported.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `id_valid`  in  1  instruction present in ID.
- `id_instr`  in  32  instruction word.
- `id_pc`  in  32  PC of that instruction.
- `rs1_data`, `rs2_data`  in  32 each  register-file read data for `id_instr[19:15]` and `id_instr[24:20]`.
- `exmem_wr`, `exmem_rd`, `exmem_result`  in  1/5/32  EX/MEM writeback forwarding source.
- `memwb_wr`, `memwb_rd`, `memwb_result`  in  1/5/32  MEM/WB writeback forwarding source.
- `stall`  in  1  hold the ID/EX register.
- `flush`  in  1  kill the instruction entering EX.
- `id_ready`  out  1  `!stall`; combinational.
- `ex_valid`  out  1  EX holds a live instruction.
- `ex_alu_a`, `ex_alu_b`  out  32 each  ALU operands.
- `ex_func`  out  4  ALU function code.
- `ex_rd`  out  5  destination register.
- `ex_reg_wr`, `ex_mem_rd`, `ex_mem_wr`  out  1 each  writeback / load / store enables.
- `ex_branch`, `ex_branch_ne`  out  1 each  BEQ / BNE indicators.
- `ex_store_data`  out  32  forwarded rs2 for stores.
- `ex_imm`  out  32  sign-extended immediate, used by the branch/address adder.
- `ex_illegal`  out  1  unsupported encoding.

## Operation
ALU function codes:
- ADD 0000, SUB 0001, OR 0010, AND 0011, SLL 0110, SRA 1001, XOR 1100, NOT 1101, SRL 1111.

Forwarding, evaluated combinationally per source register before capture:
- If `exmem_wr` and `exmem_rd == rsN` and `rsN != 0`, take `exmem_result`.
- Else if the same conditions hold for MEM/WB, take `memwb_result`.
- Else take `rsN_data`.
- rsN == 0 always yields 0.

Decode by opcode `instr[6:0]`:
- OP 0110011: a=rs1, b=rs2. funct3/funct7[5] → 000/0 ADD, 000/1 SUB, 111 AND, 110 OR, 100 XOR, 001 SLL, 101/0 SRL, 101/1 SRA. For shifts, b = {27'b0, rs2[4:0]}. `reg_wr`=1.
- OP-IMM 0010011: a=rs1, b=I-imm. Same funct3 mapping without SUB. Shifts use b = {27'b0, instr[24:20]}; instr[30] selects SRA.
- LOAD 0000011: ADD, a=rs1, b=I-imm, `mem_rd`=1, `reg_wr`=1.
- STORE 0100011: ADD, a=rs1, b=S-imm, `mem_wr`=1, `store_data`=forwarded rs2.
- BRANCH 1100011: SUB, a=rs1, b=rs2. funct3 000 → `branch`; 001 → `branch`+`branch_ne`. The downstream stage uses the ALU zero flag.
- LUI 0110111: ADD, a=0, b=U-imm, `reg_wr`=1.
- AUIPC 0010111: ADD, a=pc, b=U-imm, `reg_wr`=1.

Illegal encodings:
- Covers every other opcode or funct3: SLT/SLTU/SLTI/SLTIU, other branches, JAL, JALR, SYSTEM.
- Result: `illegal`=1, `func`=ADD, all enables 0, `valid` passes through.

Immediates are sign-extended from instr[31]. `rd` = instr[11:7]; `reg_wr` is forced to 0 when rd == 0.

## Timing
- Reset (async assert, sync release): every output register to 0, including `ex_valid`, `ex_func`, operands and enables.
- Latency: one cycle, ID edge → EX outputs.
- Per-edge priority:
  - `flush`: `ex_valid`←0, all enables←0; data fields don't-care but cleared.
  - else `stall`: all EX registers hold.
  - else capture decoded ID.
- `flush` and `stall` both high: flush wins and the bubble is inserted. Upstream must hold ID anyway, since `id_ready`=0.
- `id_valid`=0 on capture: `ex_valid`=0 and all enables 0.
- Forwarding uses source values present in the capture cycle. During stall the captured operands are not re-forwarded, so hazard control must stall the producer accordingly.
- Reset asserted mid-stall clears outputs immediately. The first post-reset edge captures normally.

## Structure
- Package `rv_pkg`: opcode constants, ALU function-code constants (shared with the ALU, replacing its local defines), immediate-format enum.
- One combinational sub-module `rv_decode`: instruction → func, operand selects, immediate, enables, illegal.
- `id_ex_stage` instantiates `rv_decode` and holds the forwarding muxes and the pipeline register.

## Test plan
- Reset: drive garbage inputs, assert `rst_n`=0 mid-cycle → all outputs 0 immediately.
- `add x3,x1,x2`, rs1=5, rs2=7 → next cycle func=0000, a=5, b=7, rd=3, reg_wr=1.
- `srai x4,x1,3` (0x4030D213), rs1=0x80000000 → func=1001, b=3.
- `sub x5,x1,x1` with exmem_wr=1, exmem_rd=1, exmem_result=9 and memwb_rd=1, memwb_result=4 → a=b=9.
- `lui x6,0x12345` at pc=0x100 → a=0, b=0x12345000, func=0000. Same encoding as AUIPC → a=0x100.
- Stall two cycles then flush+stall together: outputs hold, then `ex_valid`=0. `slt` (0x0020A1B3) → illegal=1, reg_wr=0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I decode constants: opcodes, ALU function codes (also used by the ALU),
// operand selects and immediate formats.
package rv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b1001;
  localparam logic [3:0] ALU_XOR = 4'b1100;
  localparam logic [3:0] ALU_NOT = 4'b1101;
  localparam logic [3:0] ALU_SRL = 4'b1111;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U} imm_fmt_e;
  typedef enum logic [1:0] {ASEL_ZERO, ASEL_RS1, ASEL_PC} asel_e;
  typedef enum logic [1:0] {BSEL_IMM, BSEL_RS2, BSEL_RS2_SHAMT, BSEL_IMM_SHAMT} bsel_e;

  function automatic logic signed [31:0] imm_gen(input logic [31:0] i, input imm_fmt_e fmt);
    logic signed [31:0] r;
    unique case (fmt)
      IMM_I:   r = $signed({{20{i[31]}}, i[31:20]});
      IMM_S:   r = $signed({{20{i[31]}}, i[31:25], i[11:7]});
      IMM_B:   r = $signed({{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0});
      IMM_U:   r = $signed({i[31:12], 12'b0});
      default: r = '0;
    endcase
    return r;
  endfunction

  // alt is funct7[5] already qualified by the caller (no SUB for immediates)
  function automatic logic [3:0] alu_func(input logic [2:0] f3, input logic alt);
    logic [3:0] f;
    unique case (f3)
      3'b000:  f = alt ? ALU_SUB : ALU_ADD;
      3'b001:  f = ALU_SLL;
      3'b100:  f = ALU_XOR;
      3'b101:  f = alt ? ALU_SRA : ALU_SRL;
      3'b110:  f = ALU_OR;
      3'b111:  f = ALU_AND;
      default: f = ALU_ADD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/rv_decode.sv
// Combinational RV32I decoder: instruction word to ALU function, operand selects,
// sign-extended immediate, pipeline enables and illegal flag.
module rv_decode
  import rv_pkg::*;
(
  input  logic [31:0]        instr,
  output logic [3:0]         func,
  output asel_e              asel,
  output bsel_e              bsel,
  output logic signed [31:0] imm,
  output logic               reg_wr,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic               branch,
  output logic               branch_ne,
  output logic               illegal
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic       is_shift;
  imm_fmt_e   fmt;

  assign opcode   = instr[6:0];
  assign f3       = instr[14:12];
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);
  assign imm      = imm_gen(instr, fmt);

  always_comb begin
    func      = ALU_ADD;
    asel      = ASEL_ZERO;
    bsel      = BSEL_IMM;
    fmt       = IMM_NONE;
    reg_wr    = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    branch    = 1'b0;
    branch_ne = 1'b0;
    illegal   = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        asel   = ASEL_RS1;
        bsel   = is_shift ? BSEL_RS2_SHAMT : BSEL_RS2;
        func   = alu_func(f3, instr[30]);
        reg_wr = 1'b1;
      end
      OPC_OP_IMM: begin
        asel   = ASEL_RS1;
        bsel   = is_shift ? BSEL_IMM_SHAMT : BSEL_IMM;
        fmt    = IMM_I;
        func   = alu_func(f3, (f3 == 3'b101) && instr[30]);
        reg_wr = 1'b1;
      end
      OPC_LOAD: begin
        asel   = ASEL_RS1;
        fmt    = IMM_I;
        mem_rd = 1'b1;
        reg_wr = 1'b1;
      end
      OPC_STORE: begin
        asel   = ASEL_RS1;
        fmt    = IMM_S;
        mem_wr = 1'b1;
      end
      OPC_BRANCH: begin
        asel      = ASEL_RS1;
        bsel      = BSEL_RS2;
        fmt       = IMM_B;
        func      = ALU_SUB;
        branch    = 1'b1;
        branch_ne = f3[0];
      end
      OPC_LUI: begin
        fmt    = IMM_U;
        reg_wr = 1'b1;
      end
      OPC_AUIPC: begin
        asel   = ASEL_PC;
        fmt    = IMM_U;
        reg_wr = 1'b1;
      end
      default: illegal = 1'b1;
    endcase

    // SLT/SLTU variants and all branch kinds other than BEQ/BNE are unsupported
    if (((opcode == OPC_OP) || (opcode == OPC_OP_IMM)) && (f3[2:1] == 2'b01))
      illegal = 1'b1;
    if ((opcode == OPC_BRANCH) && (f3[2:1] != 2'b00))
      illegal = 1'b1;

    if (illegal) begin
      func      = ALU_ADD;
      asel      = ASEL_ZERO;
      bsel      = BSEL_IMM;
      fmt       = IMM_NONE;
      reg_wr    = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      branch    = 1'b0;
      branch_ne = 1'b0;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX stage: decode, operand forwarding from EX/MEM and MEM/WB, and the ID/EX
// pipeline register feeding the ALU, with stall/flush from hazard control.
module id_ex_stage
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [31:0]     id_instr,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            exmem_wr,
  input  logic [4:0]      exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_wr,
  input  logic [4:0]      memwb_rd,
  input  logic [XLEN-1:0] memwb_result,
  input  logic            stall,
  input  logic            flush,
  output logic            id_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_alu_a,
  output logic [XLEN-1:0] ex_alu_b,
  output logic [3:0]      ex_func,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_wr,
  output logic            ex_mem_rd,
  output logic            ex_mem_wr,
  output logic            ex_branch,
  output logic            ex_branch_ne,
  output logic [XLEN-1:0] ex_store_data,
  output logic [XLEN-1:0] ex_imm,
  output logic            ex_illegal
);

  function automatic logic [XLEN-1:0] fwd(input logic [4:0] rs, input logic [XLEN-1:0] rf);
    logic [XLEN-1:0] v;
    if (rs == 5'd0)                            v = '0;
    else if (exmem_wr && (exmem_rd == rs))     v = exmem_result;
    else if (memwb_wr && (memwb_rd == rs))     v = memwb_result;
    else                                       v = rf;
    return v;
  endfunction

  logic [3:0]         dec_func;
  asel_e              dec_asel;
  bsel_e              dec_bsel;
  logic signed [31:0] dec_imm;
  logic               dec_reg_wr, dec_mem_rd, dec_mem_wr;
  logic               dec_branch, dec_branch_ne, dec_illegal;

  rv_decode u_dec (
    .instr     (id_instr),
    .func      (dec_func),
    .asel      (dec_asel),
    .bsel      (dec_bsel),
    .imm       (dec_imm),
    .reg_wr    (dec_reg_wr),
    .mem_rd    (dec_mem_rd),
    .mem_wr    (dec_mem_wr),
    .branch    (dec_branch),
    .branch_ne (dec_branch_ne),
    .illegal   (dec_illegal)
  );

  // Stage p0: forwarding and operand selection in ID
  logic [XLEN-1:0]        rs1_fwd_p0, rs2_fwd_p0, alu_a_p0, alu_b_p0;
  logic [4:0]             rd_p0;

  assign rs1_fwd_p0 = fwd(id_instr[19:15], rs1_data);
  assign rs2_fwd_p0 = fwd(id_instr[24:20], rs2_data);
  assign rd_p0      = id_instr[11:7];
  assign id_ready   = !stall;

  always_comb begin
    alu_a_p0 = '0;
    unique case (dec_asel)
      ASEL_RS1: alu_a_p0 = rs1_fwd_p0;
      ASEL_PC:  alu_a_p0 = id_pc;
      default:  alu_a_p0 = '0;
    endcase
  end

  always_comb begin
    alu_b_p0 = '0;
    unique case (dec_bsel)
      BSEL_RS2:       alu_b_p0 = rs2_fwd_p0;
      BSEL_RS2_SHAMT: alu_b_p0 = {{(XLEN-5){1'b0}}, rs2_fwd_p0[4:0]};
      BSEL_IMM_SHAMT: alu_b_p0 = {{(XLEN-5){1'b0}}, id_instr[24:20]};
      default:        alu_b_p0 = $unsigned(dec_imm);
    endcase
  end

  // Stage p1: ID/EX pipeline register
  logic                   vld_p1, reg_wr_p1, mem_rd_p1, mem_wr_p1;
  logic                   branch_p1, branch_ne_p1, illegal_p1;
  logic [XLEN-1:0]        alu_a_p1, alu_b_p1, store_data_p1;
  logic signed [XLEN-1:0] imm_p1;
  logic [3:0]             func_p1;
  logic [4:0]             rd_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      vld_p1        <= 1'b0;
      reg_wr_p1     <= 1'b0;
      mem_rd_p1     <= 1'b0;
      mem_wr_p1     <= 1'b0;
      branch_p1     <= 1'b0;
      branch_ne_p1  <= 1'b0;
      illegal_p1    <= 1'b0;
      alu_a_p1      <= '0;
      alu_b_p1      <= '0;
      store_data_p1 <= '0;
      imm_p1        <= '0;
      func_p1       <= '0;
      rd_p1         <= '0;
    end else if (!stall) begin
      vld_p1        <= id_valid;
      reg_wr_p1     <= id_valid && dec_reg_wr && (rd_p0 != 5'd0);
      mem_rd_p1     <= id_valid && dec_mem_rd;
      mem_wr_p1     <= id_valid && dec_mem_wr;
      branch_p1     <= id_valid && dec_branch;
      branch_ne_p1  <= id_valid && dec_branch_ne;
      illegal_p1    <= id_valid && dec_illegal;
      alu_a_p1      <= alu_a_p0;
      alu_b_p1      <= alu_b_p0;
      store_data_p1 <= rs2_fwd_p0;
      imm_p1        <= dec_imm;
      func_p1       <= dec_func;
      rd_p1         <= rd_p0;
    end
  end

  assign ex_valid      = vld_p1;
  assign ex_alu_a      = alu_a_p1;
  assign ex_alu_b      = alu_b_p1;
  assign ex_func       = func_p1;
  assign ex_rd         = rd_p1;
  assign ex_reg_wr     = reg_wr_p1;
  assign ex_mem_rd     = mem_rd_p1;
  assign ex_mem_wr     = mem_wr_p1;
  assign ex_branch     = branch_p1;
  assign ex_branch_ne  = branch_ne_p1;
  assign ex_store_data = store_data_p1;
  assign ex_imm        = $unsigned(imm_p1);
  assign ex_illegal    = illegal_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed literal cases plus random instruction traffic
// compared every cycle against a mnemonic-level reference model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [31:0] id_instr = '0, id_pc = '0, rs1_data = '0, rs2_data = '0;
  logic        exmem_wr = 1'b0, memwb_wr = 1'b0;
  logic [4:0]  exmem_rd = '0, memwb_rd = '0;
  logic [31:0] exmem_result = '0, memwb_result = '0;
  logic        stall = 1'b0, flush = 1'b0;
  logic        id_ready, ex_valid, ex_reg_wr, ex_mem_rd, ex_mem_wr;
  logic        ex_branch, ex_branch_ne, ex_illegal;
  logic [31:0] ex_alu_a, ex_alu_b, ex_store_data, ex_imm;
  logic [3:0]  ex_func;
  logic [4:0]  ex_rd;

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  id_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .exmem_wr(exmem_wr), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_wr(memwb_wr), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .stall(stall), .flush(flush), .id_ready(id_ready), .ex_valid(ex_valid),
    .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b), .ex_func(ex_func), .ex_rd(ex_rd),
    .ex_reg_wr(ex_reg_wr), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .ex_branch(ex_branch), .ex_branch_ne(ex_branch_ne), .ex_store_data(ex_store_data),
    .ex_imm(ex_imm), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid, reg_wr, mem_rd, mem_wr, br, brne, ill;
    logic [31:0] a, b, sd, imm;
    logic [3:0]  func;
    logic [4:0]  rd;
    logic        full, sd_chk, imm_chk;
  } exp_t;

  exp_t exp_q;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, req);
    end
  endtask

  function automatic exp_t zero_exp();
    exp_t e = '0;
    e.full = 1'b1; e.sd_chk = 1'b1; e.imm_chk = 1'b1;
    return e;
  endfunction

  function automatic logic [31:0] fv(input logic [4:0] r, input logic [31:0] rf);
    if (r == 0) return 32'd0;
    if (exmem_wr && exmem_rd == r) return exmem_result;
    if (memwb_wr && memwb_rd == r) return memwb_result;
    return rf;
  endfunction

  // Reference: what the architecture says each instruction feeds the ALU
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc,
                                 input logic [31:0] r1, input logic [31:0] r2, input logic v);
    exp_t e = '0;
    logic [31:0] s1, s2, iimm, simm, bimm, uimm;
    logic legal, wr;
    s1 = fv(i[19:15], r1);
    s2 = fv(i[24:20], r2);
    iimm = {{20{i[31]}}, i[31:20]};
    simm = {{20{i[31]}}, i[31:25], i[11:7]};
    bimm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    uimm = {i[31:12], 12'd0};
    legal = 1'b1; wr = 1'b0;
    e.valid = v; e.rd = i[11:7]; e.full = 1'b1; e.imm_chk = 1'b1;
    case (i[6:0])
      7'h33, 7'h13: begin
        e.a = s1; wr = 1'b1;
        e.b = (i[6:0] == 7'h33) ? s2 : iimm;
        e.imm = (i[6:0] == 7'h33) ? 32'd0 : iimm;
        e.imm_chk = (i[6:0] == 7'h13);
        case (i[14:12])
          3'd0: e.func = (i[6:0] == 7'h33 && i[30]) ? 4'b0001 : 4'b0000;
          3'd7: e.func = 4'b0011;
          3'd6: e.func = 4'b0010;
          3'd4: e.func = 4'b1100;
          3'd1: e.func = 4'b0110;
          3'd5: e.func = i[30] ? 4'b1001 : 4'b1111;
          default: legal = 1'b0;
        endcase
        if (i[14:12] == 3'd1 || i[14:12] == 3'd5)
          e.b = (i[6:0] == 7'h33) ? (s2 & 32'h1f) : {27'd0, i[24:20]};
      end
      7'h03: begin e.a = s1; e.b = iimm; e.imm = iimm; e.mem_rd = 1'b1; wr = 1'b1; end
      7'h23: begin e.a = s1; e.b = simm; e.imm = simm; e.mem_wr = 1'b1; e.sd = s2; e.sd_chk = 1'b1; end
      7'h63: begin
        e.func = 4'b0001; e.a = s1; e.b = s2; e.imm = bimm;
        if (i[14:12] == 3'd0) e.br = 1'b1;
        else if (i[14:12] == 3'd1) begin e.br = 1'b1; e.brne = 1'b1; end
        else legal = 1'b0;
      end
      7'h37: begin e.a = 32'd0; e.b = uimm; e.imm = uimm; wr = 1'b1; end
      7'h17: begin e.a = pc; e.b = uimm; e.imm = uimm; wr = 1'b1; end
      default: legal = 1'b0;
    endcase
    e.reg_wr = wr && (i[11:7] != 0);
    if (!legal) begin
      e.func = 4'b0000; e.reg_wr = 0; e.mem_rd = 0; e.mem_wr = 0; e.br = 0; e.brne = 0;
      e.ill = 1'b1; e.full = 1'b0;
    end
    if (!v) begin
      e.reg_wr = 0; e.mem_rd = 0; e.mem_wr = 0; e.br = 0; e.brne = 0; e.ill = 0; e.full = 0;
    end
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) exp_q = zero_exp();
    else if (!stall) exp_q = model(id_instr, id_pc, rs1_data, rs2_data, id_valid);
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("valid", {31'd0, ex_valid}, {31'd0, exp_q.valid});
      chk("reg_wr", {31'd0, ex_reg_wr}, {31'd0, exp_q.reg_wr});
      chk("mem_rd", {31'd0, ex_mem_rd}, {31'd0, exp_q.mem_rd});
      chk("mem_wr", {31'd0, ex_mem_wr}, {31'd0, exp_q.mem_wr});
      chk("branch", {31'd0, ex_branch}, {31'd0, exp_q.br});
      chk("branch_ne", {31'd0, ex_branch_ne}, {31'd0, exp_q.brne});
      chk("illegal", {31'd0, ex_illegal}, {31'd0, exp_q.ill});
      if (exp_q.full || exp_q.ill) chk("func", {28'd0, ex_func}, {28'd0, exp_q.func});
      if (exp_q.full) begin
        chk("alu_a", ex_alu_a, exp_q.a);
        chk("alu_b", ex_alu_b, exp_q.b);
        chk("rd", {27'd0, ex_rd}, {27'd0, exp_q.rd});
        if (exp_q.imm_chk) chk("imm", ex_imm, exp_q.imm);
        if (exp_q.sd_chk) chk("store_data", ex_store_data, exp_q.sd);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic put(input logic [31:0] ins, input logic [31:0] pc,
                     input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    id_valid = 1'b1; id_instr = ins; id_pc = pc; rs1_data = a; rs2_data = b;
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] r, ins;
    logic [4:0] rd, s1, s2;
    logic [2:0] f3;
    logic [6:0] f7;
    r = $urandom;
    rd = 5'($urandom_range(0, 7)); s1 = 5'($urandom_range(0, 7)); s2 = 5'($urandom_range(0, 7));
    f3 = r[14:12];
    f7 = ((f3 == 3'd0 || f3 == 3'd5) && r[30]) ? 7'h20 : 7'h00;
    case ($urandom_range(0, 9))
      0, 1, 9: ins = {f7, s2, s1, f3, rd, 7'h33};
      2, 3:    ins = (f3 == 3'd1 || f3 == 3'd5) ? {f7, r[24:20], s1, f3, rd, 7'h13}
                                                  : {r[31:20], s1, f3, rd, 7'h13};
      4:       ins = {r[31:20], s1, 3'd2, rd, 7'h03};
      5:       ins = {r[31:25], s2, s1, 3'd2, r[11:7], 7'h23};
      6:       ins = {r[31:25], s2, s1, f3, r[11:7], 7'h63};
      7:       ins = {r[31:12], rd, r[0] ? 7'h37 : 7'h17};
      default: ins = r;
    endcase
    return ins;
  endfunction

  initial begin
    @(posedge clk); #1;
    chk_on = 1'b1;
    chk("reset_valid", {31'd0, ex_valid}, 32'd0);
    chk("reset_func", {28'd0, ex_func}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    put(32'h002081B3, 32'h0, 32'd5, 32'd7); step();
    chk("add_func", {28'd0, ex_func}, 32'd0);
    chk("add_a", ex_alu_a, 32'd5);
    chk("add_b", ex_alu_b, 32'd7);
    chk("add_rd", {27'd0, ex_rd}, 32'd3);
    chk("add_reg_wr", {31'd0, ex_reg_wr}, 32'd1);

    put(32'h4030D213, 32'h0, 32'h80000000, 32'd0); step();
    chk("srai_func", {28'd0, ex_func}, 32'd9);
    chk("srai_b", ex_alu_b, 32'd3);
    chk("srai_a", ex_alu_a, 32'h80000000);

    put(32'h401082B3, 32'h0, 32'd100, 32'd100);
    exmem_wr = 1'b1; exmem_rd = 5'd1; exmem_result = 32'd9;
    memwb_wr = 1'b1; memwb_rd = 5'd1; memwb_result = 32'd4;
    step();
    chk("sub_fwd_a", ex_alu_a, 32'd9);
    chk("sub_fwd_b", ex_alu_b, 32'd9);
    chk("sub_func", {28'd0, ex_func}, 32'd1);
    @(negedge clk); exmem_wr = 1'b0; memwb_wr = 1'b0;

    put(32'h12345337, 32'h100, 32'd1, 32'd2); step();
    chk("lui_a", ex_alu_a, 32'd0);
    chk("lui_b", ex_alu_b, 32'h12345000);
    chk("lui_func", {28'd0, ex_func}, 32'd0);
    put(32'h12345317, 32'h100, 32'd1, 32'd2); step();
    chk("auipc_a", ex_alu_a, 32'h100);
    chk("auipc_b", ex_alu_b, 32'h12345000);

    put(32'h002081B3, 32'h0, 32'd5, 32'd7); step();
    put(32'h0020A1B3, 32'h0, 32'd11, 32'd13); stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("stall_hold_a", ex_alu_a, 32'd5);
      chk("stall_hold_valid", {31'd0, ex_valid}, 32'd1);
      chk("stall_id_ready", {31'd0, id_ready}, 32'd0);
    end
    @(negedge clk); flush = 1'b1; step();
    chk("flush_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_reg_wr", {31'd0, ex_reg_wr}, 32'd0);
    chk("flush_a", ex_alu_a, 32'd0);
    @(negedge clk); flush = 1'b0; stall = 1'b0; step();
    chk("slt_illegal", {31'd0, ex_illegal}, 32'd1);
    chk("slt_reg_wr", {31'd0, ex_reg_wr}, 32'd0);
    chk("slt_valid", {31'd0, ex_valid}, 32'd1);

    put(32'h002081B3, 32'h0, 32'd5, 32'd7); step();
    @(negedge clk); stall = 1'b1; id_instr = 32'hFFFFFFFF; rs1_data = 32'hDEADBEEF;
    @(posedge clk); #2; rst_n = 1'b0; #1;
    chk("rst_mid_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_mid_a", ex_alu_a, 32'd0);
    chk("rst_mid_reg_wr", {31'd0, ex_reg_wr}, 32'd0);
    put(32'h002081B3, 32'h0, 32'd5, 32'd7); stall = 1'b0; rst_n = 1'b1; step();
    chk("post_rst_a", ex_alu_a, 32'd5);
    chk("post_rst_valid", {31'd0, ex_valid}, 32'd1);

    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      id_valid = ($urandom_range(0, 99) < 85);
      id_instr = gen_instr();
      id_pc = $urandom & 32'hFFFFFFFC;
      rs1_data = $urandom; rs2_data = $urandom;
      exmem_wr = $urandom_range(0, 1) == 1; exmem_rd = 5'($urandom_range(0, 7)); exmem_result = $urandom;
      memwb_wr = $urandom_range(0, 1) == 1; memwb_rd = 5'($urandom_range(0, 7)); memwb_result = $urandom;
      stall = ($urandom_range(0, 99) < 15);
      flush = ($urandom_range(0, 99) < 8);
    end
    @(negedge clk); stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
    step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
